code_lock_ctrl: RTL and testbench
=================================

# code_lock_ctrl

Parametrised keypad lock controller: the next generation of the lock decider, generalised to an N-digit code with a configurable retry limit, timed lockout, timed open window and in-field code change. It sits between the keypad scanner, which supplies one-cycle `key_valid` pulses with a 4-bit `key_code`, and the segment display driver, which consumes the packed entry digits and the wrong-attempt count.

## Interface
- `DIGITS`, 4: code length in digits, 1..8.
- `MAX_TRIES`, 3: consecutive wrong attempts that trigger lockout, 1..15.
- `OPEN_CYC`, 32'd100_000_000: cycles the lock stays open.
- `LOCKOUT_CYC`, 32'd500_000_000: cycles of lockout.
- `DEFAULT_CODE`, 32'h0000_1234: reset code; the low `4*DIGITS` bits are used, one BCD digit per nibble.
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `key_valid` in 1: one-cycle pulse, key press accepted.
- `key_code` in 4: 0-9 digit, `4'hA` enter, `4'hB` backspace, `4'hC` change-code, `4'hD`-`4'hF` ignored.
- `open` out 1: lock released.
- `locked` out 1: lock engaged (equals `~open`).
- `lockout` out 1: retry limit reached, keys ignored.
- `change_mode` out 1: new-code entry in progress.
- `save_light` out 1: new code committed; held until the next accepted key or reset.
- `entry_digits` out `4*DIGITS`: entered digits, newest digit in nibble 0; unused nibbles are 0.
- `entry_count` out `$clog2(DIGITS+1)`: number of digits entered.
- `wrong_count` out 4: consecutive wrong attempts.

## Operation
- States: IDLE, ENTRY, CHECK, OPEN, CHG_NEW, CHG_CONFIRM, LOCKOUT.
- Reset: state IDLE; stored code = `DEFAULT_CODE`; `open`=0, `locked`=1, `lockout`=0, `change_mode`=0, `save_light`=0, `entry_digits`=0, `entry_count`=0, `wrong_count`=0.
- IDLE/ENTRY digit:
  - Shift into `entry_digits` (`{entry_digits[4*DIGITS-5:0], key_code}`).
  - Increment `entry_count` and go to ENTRY.
  - When `entry_count`==DIGITS the digit is ignored and there is no shift.
- Backspace:
  - Shift right by one nibble and decrement `entry_count`.
  - No-op when `entry_count`==0.
- Enter in IDLE/ENTRY: go to CHECK. A match requires `entry_count`==DIGITS and `entry_digits` == stored code; a short entry is a wrong attempt.
- CHECK (one cycle):
  - On match: clear `wrong_count` and go to OPEN.
  - Otherwise increment `wrong_count`, saturating at 15. Go to LOCKOUT if the new count equals MAX_TRIES, else IDLE.
  - The entry is cleared in both cases.
- OPEN:
  - `open`=1 for `OPEN_CYC` cycles, then IDLE.
  - Change-code key goes to CHG_NEW with `open` dropped.
  - Other keys are ignored.
- CHG_NEW:
  - Digits and backspace behave as in ENTRY.
  - Enter with `entry_count`==DIGITS captures the candidate code; the next state depends on the macro (see Configuration).
  - Enter when the entry is short clears the entry and stays in CHG_NEW.
  - Change-code key aborts to IDLE with the stored code unchanged.
- LOCKOUT:
  - `lockout`=1 for `LOCKOUT_CYC` cycles; all keys are ignored.
  - On exit: `wrong_count`=0, go to IDLE.
- `change_mode`=1 in CHG_NEW and CHG_CONFIRM.
- Unused `key_code` values are ignored in every state.

## Timing
- All outputs are registered; a key pulse in cycle t is visible at t+1.
- Enter at t: CHECK at t+1; `open`/`lockout`/`wrong_count` update at t+2.
- `open` is high for exactly `OPEN_CYC` cycles; `lockout` is high for exactly `LOCKOUT_CYC` cycles.
- Timer width is `$clog2` of the larger of the two cycle counts. The timer loads on state entry and is idle otherwise.
- A `key_valid` arriving during CHECK is dropped.
- `reset` has priority over every event, including mid-lockout and mid-change. It restores `DEFAULT_CODE`.

## Configuration
- `CODE_LOCK_CONFIRM_EN` defined:
  - Enter in CHG_NEW stores the candidate, clears the entry and goes to CHG_CONFIRM.
  - In CHG_CONFIRM, a matching DIGITS-digit entry plus enter commits the code, sets `save_light` and goes to IDLE.
  - A mismatch discards the candidate and returns to CHG_NEW.
- Undefined: CHG_CONFIRM does not exist; enter in CHG_NEW commits immediately, sets `save_light` and goes to IDLE.

## Test plan
- DIGITS=4, reset, keys 1,2,3,4,A -> `open`=1 at t+2 after A, held exactly `OPEN_CYC` (bench 20) cycles, `wrong_count`=0.
- Keys 1,2,3,5,A three times (MAX_TRIES=3) -> `wrong_count` 1,2,3; `lockout`=1 for `LOCKOUT_CYC` (bench 50) cycles; keys during lockout are ignored; `wrong_count`=0 on exit.
- Keys 1,2,B,B,B,9 -> `entry_count` goes 1,2,1,0,0,1; `entry_digits`=16'h0009.
- Enter 1,2,3,4,A, then C,5,6,7,8,A (confirm build: +5,6,7,8,A) -> `save_light`=1; then 5,6,7,8,A opens and 1,2,3,4,A is wrong.
- Confirm build, change with 5,6,7,8,A then 5,6,7,9,A -> back to CHG_NEW, code still 1234.
- Assert `reset` mid-CHG_NEW and mid-LOCKOUT -> all outputs return to reset values next cycle; 1,2,3,4,A opens.

Source files
------------

// File: rtl/code_lock_ctrl_if.sv
// Keypad-to-lock and lock-to-display bundle for code_lock_ctrl.
// master: keypad/display side (drives keys); slave: the lock controller.
interface code_lock_ctrl_if #(
  parameter int unsigned DIGITS = 4
);
  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned CW = $clog2(DIGITS + 1);

  logic          key_valid;
  logic [3:0]    key_code;
  logic          open;
  logic          locked;
  logic          lockout;
  logic          change_mode;
  logic          save_light;
  logic [W-1:0]  entry_digits;
  logic [CW-1:0] entry_count;
  logic [3:0]    wrong_count;

  modport master (
    output key_valid,
    output key_code,
    input  open,
    input  locked,
    input  lockout,
    input  change_mode,
    input  save_light,
    input  entry_digits,
    input  entry_count,
    input  wrong_count
  );

  modport slave (
    input  key_valid,
    input  key_code,
    output open,
    output locked,
    output lockout,
    output change_mode,
    output save_light,
    output entry_digits,
    output entry_count,
    output wrong_count
  );
endinterface

// File: rtl/code_lock_ctrl.sv
// N-digit keypad lock: retry limit, timed lockout/open, in-field code change.
// Ports: clock, reset (sync, high), bus (slave): key_valid/key_code in;
// open, locked, lockout, change_mode, save_light, entry_digits,
// entry_count, wrong_count out. Optional: CODE_LOCK_CONFIRM_EN enables
// a second (confirmation) entry of the new code before it is committed.
module code_lock_ctrl #(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned MAX_TRIES    = 3,
  parameter logic [31:0] OPEN_CYC     = 32'd100_000_000,
  parameter logic [31:0] LOCKOUT_CYC  = 32'd500_000_000,
  parameter logic [31:0] DEFAULT_CODE = 32'h0000_1234
) (
  input  logic             clock,
  input  logic             reset,
  code_lock_ctrl_if.slave  bus
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned CW = $clog2(DIGITS + 1);
  localparam logic [31:0] MAXC =
    (OPEN_CYC > LOCKOUT_CYC) ? OPEN_CYC : LOCKOUT_CYC;
  localparam int unsigned TW = (MAXC > 32'd1) ? $clog2(MAXC) : 1;

  localparam logic [TW-1:0] OPEN_LD = TW'(OPEN_CYC - 32'd1);
  localparam logic [TW-1:0] LOCK_LD = TW'(LOCKOUT_CYC - 32'd1);
  localparam logic [CW-1:0] FULL_N  = CW'(DIGITS);
  localparam logic [3:0]    TRIES_N = 4'(MAX_TRIES);
  localparam logic [W-1:0]  CODE_RST = DEFAULT_CODE[W-1:0];

  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    CHECK,
    OPEN,
    CHG_NEW,
`ifdef CODE_LOCK_CONFIRM_EN
    CHG_CONFIRM,
`endif
    LOCKOUT
  } state_e;

  state_e        state_q;
  logic [W-1:0]  code_q;
  logic [W-1:0]  entry_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    wrong_q;
  logic [TW-1:0] timer_q;
  logic          open_q;
  logic          lockout_q;
  logic          change_q;
  logic          save_q;
`ifdef CODE_LOCK_CONFIRM_EN
  logic [W-1:0]  cand_q;
`endif

  // Key decode
  logic kv_dig;
  logic kv_ent;
  logic kv_bsp;
  logic kv_chg;
  logic kv_any;

  always_comb begin
    kv_dig = 1'b0;
    kv_ent = 1'b0;
    kv_bsp = 1'b0;
    kv_chg = 1'b0;
    if (bus.key_valid) begin
      unique case (1'b1)
        (bus.key_code <= 4'd9):  kv_dig = 1'b1;
        (bus.key_code == 4'hA):  kv_ent = 1'b1;
        (bus.key_code == 4'hB):  kv_bsp = 1'b1;
        (bus.key_code == 4'hC):  kv_chg = 1'b1;
        default: ;
      endcase
    end
  end

  assign kv_any = kv_dig | kv_ent | kv_bsp | kv_chg;

  // Entry-buffer helpers shared by all digit-collecting states
  logic          full;
  logic          empty;
  logic          edit_st;
  logic [W-1:0]  ent_shl_d;
  logic [W-1:0]  ent_shr_d;
  logic [CW-1:0] cnt_inc_d;
  logic [CW-1:0] cnt_dec_d;
  logic          match_d;
  logic [3:0]    wr_inc_d;

  assign full      = (cnt_q == FULL_N);
  assign empty     = (cnt_q == '0);
  assign ent_shl_d = (entry_q << 4) | W'(bus.key_code);
  assign ent_shr_d = entry_q >> 4;
  assign cnt_inc_d = cnt_q + CW'(1);
  assign cnt_dec_d = cnt_q - CW'(1);
  assign match_d   = full && (entry_q == code_q);
  assign wr_inc_d  = (wrong_q == 4'hF) ? 4'hF : wrong_q + 4'd1;

  always_comb begin
    edit_st = 1'b0;
    unique case (state_q)
      IDLE, ENTRY, CHG_NEW: edit_st = 1'b1;
`ifdef CODE_LOCK_CONFIRM_EN
      CHG_CONFIRM:          edit_st = 1'b1;
`endif
      default:              edit_st = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      code_q    <= CODE_RST;
      entry_q   <= '0;
      cnt_q     <= '0;
      wrong_q   <= '0;
      timer_q   <= '0;
      open_q    <= 1'b0;
      lockout_q <= 1'b0;
      change_q  <= 1'b0;
      save_q    <= 1'b0;
`ifdef CODE_LOCK_CONFIRM_EN
      cand_q    <= '0;
`endif
    end else begin
      // Any recognised key clears the save indicator; keys during
      // CHECK and LOCKOUT are not accepted.
      if (kv_any && state_q != CHECK && state_q != LOCKOUT)
        save_q <= 1'b0;

      // Digit/backspace editing; enter handling below overrides it.
      if (edit_st) begin
        if (kv_dig && !full) begin
          entry_q <= ent_shl_d;
          cnt_q   <= cnt_inc_d;
        end else if (kv_bsp && !empty) begin
          entry_q <= ent_shr_d;
          cnt_q   <= cnt_dec_d;
        end
      end

      case (state_q)
        IDLE, ENTRY: begin
          if (kv_ent)
            state_q <= CHECK;
          else if (kv_dig)
            state_q <= ENTRY;
        end

        CHECK: begin
          entry_q <= '0;
          cnt_q   <= '0;
          if (match_d) begin
            wrong_q <= '0;
            open_q  <= 1'b1;
            timer_q <= OPEN_LD;
            state_q <= OPEN;
          end else begin
            wrong_q <= wr_inc_d;
            if (wr_inc_d == TRIES_N) begin
              lockout_q <= 1'b1;
              timer_q   <= LOCK_LD;
              state_q   <= LOCKOUT;
            end else begin
              state_q <= IDLE;
            end
          end
        end

        OPEN: begin
          if (kv_chg) begin
            open_q   <= 1'b0;
            change_q <= 1'b1;
            timer_q  <= '0;
            state_q  <= CHG_NEW;
          end else if (timer_q == '0) begin
            open_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end

        CHG_NEW: begin
          if (kv_ent) begin
            entry_q <= '0;
            cnt_q   <= '0;
            if (full) begin
`ifdef CODE_LOCK_CONFIRM_EN
              cand_q  <= entry_q;
              state_q <= CHG_CONFIRM;
`else
              code_q   <= entry_q;
              save_q   <= 1'b1;
              change_q <= 1'b0;
              state_q  <= IDLE;
`endif
            end
          end else if (kv_chg) begin
            entry_q  <= '0;
            cnt_q    <= '0;
            change_q <= 1'b0;
            state_q  <= IDLE;
          end
        end

`ifdef CODE_LOCK_CONFIRM_EN
        CHG_CONFIRM: begin
          if (kv_ent) begin
            entry_q <= '0;
            cnt_q   <= '0;
            if (full && entry_q == cand_q) begin
              code_q   <= cand_q;
              save_q   <= 1'b1;
              change_q <= 1'b0;
              state_q  <= IDLE;
            end else begin
              cand_q  <= '0;
              state_q <= CHG_NEW;
            end
          end else if (kv_chg) begin
            entry_q  <= '0;
            cnt_q    <= '0;
            cand_q   <= '0;
            change_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
`endif

        LOCKOUT: begin
          if (timer_q == '0) begin
            lockout_q <= 1'b0;
            wrong_q   <= '0;
            state_q   <= IDLE;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.open         = open_q;
  assign bus.locked       = ~open_q;
  assign bus.lockout      = lockout_q;
  assign bus.change_mode  = change_q;
  assign bus.save_light   = save_q;
  assign bus.entry_digits = entry_q;
  assign bus.entry_count  = cnt_q;
  assign bus.wrong_count  = wrong_q;

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Directed bench for code_lock_ctrl (DIGITS=4, MAX_TRIES=3,
// OPEN_CYC=20, LOCKOUT_CYC=50); works with or without CODE_LOCK_CONFIRM_EN.
module tb_code_lock_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  code_lock_ctrl_if #(.DIGITS(4)) bus ();

  code_lock_ctrl #(
    .DIGITS      (4),
    .MAX_TRIES   (3),
    .OPEN_CYC    (32'd20),
    .LOCKOUT_CYC (32'd50),
    .DEFAULT_CODE(32'h0000_1234)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // {open, locked, lockout, change, save, count[2:0], wrong[3:0]}
  function automatic logic [31:0] stat();
    return {20'd0, bus.open, bus.locked, bus.lockout, bus.change_mode,
            bus.save_light, bus.entry_count, bus.wrong_count};
  endfunction

  task automatic press(input logic [3:0] k);
    bus.key_code  = k;
    bus.key_valid = 1'b1;
    @(negedge clk);
    bus.key_valid = 1'b0;
  endtask

  task automatic code(input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] c, input logic [3:0] d);
    press(a);
    press(b);
    press(c);
    press(d);
    press(4'hA);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_open_low();
    int n = 0;
    while (bus.open && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("open_drop", 32'(n < 200), 32'd1);
  endtask

  initial begin
    int n;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
    @(negedge clk);
    do_reset();
    chk("rst_stat", stat(), 32'h400);
    chk("rst_dig", 32'(bus.entry_digits), 32'h0);

    // Correct code opens for exactly 20 cycles
    press(4'h1);
    chk("cnt1", 32'(bus.entry_count), 32'd1);
    press(4'h2);
    press(4'h3);
    press(4'h4);
    chk("dig1234", 32'(bus.entry_digits), 32'h1234);
    chk("cnt4", 32'(bus.entry_count), 32'd4);
    press(4'hA);
    chk("chk_cyc_open", 32'(bus.open), 32'd0);
    @(negedge clk);
    chk("open_stat", stat(), 32'h800);
    n = 0;
    while (bus.open && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("open_len", 32'(n), 32'd20);
    chk("relock", stat(), 32'h400);

    // Full entry ignores extra digit; short entry is wrong
    code(4'h1, 4'h2, 4'h3, 4'h4);
    do_reset();
    press(4'h1);
    press(4'h2);
    press(4'h3);
    press(4'h4);
    press(4'h5);
    chk("full_cnt", 32'(bus.entry_count), 32'd4);
    chk("full_dig", 32'(bus.entry_digits), 32'h1234);
    press(4'hB);
    chk("bs_dig", 32'(bus.entry_digits), 32'h0123);
    press(4'hA);
    @(negedge clk);
    chk("short_wrong", stat(), 32'h401);

    // Three wrong attempts -> lockout for 50 cycles, keys ignored
    do_reset();
    code(4'h1, 4'h2, 4'h3, 4'h5);
    @(negedge clk);
    chk("wrong1", 32'(bus.wrong_count), 32'd1);
    code(4'h1, 4'h2, 4'h3, 4'h5);
    @(negedge clk);
    chk("wrong2", 32'(bus.wrong_count), 32'd2);
    code(4'h1, 4'h2, 4'h3, 4'h5);
    @(negedge clk);
    chk("lock_stat", stat(), 32'h603);
    n = 0;
    while (bus.lockout && n < 200) begin
      bus.key_code  = 4'h1;
      bus.key_valid = (n % 3 == 0);
      n++;
      @(negedge clk);
    end
    bus.key_valid = 1'b0;
    chk("lock_len", 32'(n), 32'd50);
    chk("lock_exit", stat(), 32'h400);

    // Backspace and ignored key
    do_reset();
    press(4'hD);
    chk("key_d", stat(), 32'h400);
    press(4'h1);
    chk("bs_c1", 32'(bus.entry_count), 32'd1);
    press(4'h2);
    chk("bs_c2", 32'(bus.entry_count), 32'd2);
    press(4'hB);
    chk("bs_c3", 32'(bus.entry_count), 32'd1);
    press(4'hB);
    chk("bs_c4", 32'(bus.entry_count), 32'd0);
    press(4'hB);
    chk("bs_c5", 32'(bus.entry_count), 32'd0);
    press(4'h9);
    chk("bs_c6", 32'(bus.entry_count), 32'd1);
    chk("bs_dig9", 32'(bus.entry_digits), 32'h0009);

    // Code change to 5678
    do_reset();
    code(4'h1, 4'h2, 4'h3, 4'h4);
    @(negedge clk);
    press(4'hC);
    chk("chg_enter", stat(), 32'h500);
    code(4'h5, 4'h6, 4'h7, 4'h8);
`ifdef CODE_LOCK_CONFIRM_EN
    chk("chg_confirm", stat(), 32'h500);
    code(4'h5, 4'h6, 4'h7, 4'h8);
`endif
    chk("saved", stat(), 32'h480);
    press(4'h5);
    chk("save_clr", 32'(bus.save_light), 32'd0);
    press(4'h6);
    press(4'h7);
    press(4'h8);
    press(4'hA);
    @(negedge clk);
    chk("new_open", 32'(bus.open), 32'd1);
    wait_open_low();
    code(4'h1, 4'h2, 4'h3, 4'h4);
    @(negedge clk);
    chk("old_wrong", stat(), 32'h401);
    do_reset();
    code(4'h1, 4'h2, 4'h3, 4'h4);
    @(negedge clk);
    chk("rst_default", 32'(bus.open), 32'd1);
    wait_open_low();

`ifdef CODE_LOCK_CONFIRM_EN
    // Confirmation mismatch keeps the old code
    code(4'h1, 4'h2, 4'h3, 4'h4);
    @(negedge clk);
    press(4'hC);
    code(4'h5, 4'h6, 4'h7, 4'h8);
    code(4'h5, 4'h6, 4'h7, 4'h9);
    chk("cf_back", stat(), 32'h500);
    press(4'hC);
    code(4'h1, 4'h2, 4'h3, 4'h4);
    @(negedge clk);
    chk("cf_keep", 32'(bus.open), 32'd1);
    wait_open_low();
`endif

    // Reset mid-change
    code(4'h1, 4'h2, 4'h3, 4'h4);
    @(negedge clk);
    press(4'hC);
    press(4'h5);
    press(4'h6);
    do_reset();
    chk("rst_chg", stat(), 32'h400);
    chk("rst_chg_dig", 32'(bus.entry_digits), 32'h0);
    code(4'h1, 4'h2, 4'h3, 4'h4);
    @(negedge clk);
    chk("rst_chg_open", 32'(bus.open), 32'd1);
    wait_open_low();

    // Reset mid-lockout
    for (int i = 0; i < 3; i++) begin
      code(4'h9, 4'h9, 4'h9, 4'h9);
      @(negedge clk);
    end
    chk("lk2_stat", 32'(bus.lockout), 32'd1);
    repeat (5) @(negedge clk);
    do_reset();
    chk("rst_lock", stat(), 32'h400);
    code(4'h1, 4'h2, 4'h3, 4'h4);
    @(negedge clk);
    chk("rst_lock_open", 32'(bus.open), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
